// File: rtl/approx_madd_pkg.sv
// Shared width helpers, partial-product column mask and stage payload type for the
// approximate multiply-add pipeline.
package approx_madd_pkg;

  function automatic int unsigned out_w(input int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned lvl_w(input int unsigned w);
    return $clog2(2 * w) + 1;
  endfunction

  // The top column 2W-2 is never dropped, so large levels clamp to it.
  function automatic logic pp_keep(input int i, input int j, input int k, input int w);
    int top_col;
    int k_eff;
    top_col = 2 * w - 2;
    k_eff   = (k > top_col) ? top_col : k;
    return (i + j) >= k_eff;
  endfunction

  typedef struct packed {
    logic valid;
    logic viol;
  } stage_flags_t;

endpackage

// File: rtl/approx_madd_core.sv
// Combinational exact and column-truncated approximate a*b + c.
module approx_madd_core
  import approx_madd_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned LVL_W = 4
) (
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  input  logic [LVL_W-1:0] k,
  output logic [OUT_W-1:0] sum_exact,
  output logic [OUT_W-1:0] sum_approx
);

  always_comb begin
    sum_exact  = OUT_W'(a) * OUT_W'(b) + OUT_W'(c);
    sum_approx = OUT_W'(c);
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if (a[i] && b[j] && pp_keep(i, j, int'(32'(k)), int'(W))) begin
          sum_approx = sum_approx + (OUT_W'(1) << (i + j));
        end
      end
    end
  end

endmodule

// File: rtl/approx_madd_pipe.sv
// Two-stage valid/ready approximate multiply-add with error threshold and saturating
// statistics (transactions, violations, maximum error).
module approx_madd_pipe
  import approx_madd_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned ET    = 7,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  input  logic [W-1:0]          c,
  input  logic [$clog2(2*W):0]  lvl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*W-1:0]        y,
  output logic [2*W-1:0]        y_exact,
  output logic [2*W-1:0]        err,
  output logic                  viol,
  input  logic                  stat_clr,
  output logic [CNT_W-1:0]      txn_cnt,
  output logic [CNT_W-1:0]      viol_cnt,
  output logic [2*W-1:0]        max_err
);

  localparam int unsigned OUT_W = out_w(W);
  localparam int unsigned LVL_W = lvl_w(W);

  logic             en;
  logic             hs;
  logic [OUT_W-1:0] core_exact;
  logic [OUT_W-1:0] core_approx;
  logic [OUT_W-1:0] s1_diff;

  logic             s1_valid_q;
  logic [OUT_W-1:0] s1_exact_q;
  logic [OUT_W-1:0] s1_approx_q;

  stage_flags_t     s2_q;
  logic [OUT_W-1:0] y_q;
  logic [OUT_W-1:0] y_exact_q;
  logic [OUT_W-1:0] err_q;

  logic [CNT_W-1:0] txn_cnt_q;
  logic [CNT_W-1:0] viol_cnt_q;
  logic [OUT_W-1:0] max_err_q;

  assign en       = ~s2_q.valid | out_ready;
  assign in_ready = en;
  assign hs       = s2_q.valid & out_ready;
  assign s1_diff  = s1_exact_q - s1_approx_q;

  approx_madd_core #(
    .W     (W),
    .OUT_W (OUT_W),
    .LVL_W (LVL_W)
  ) u_core (
    .a          (a),
    .b          (b),
    .c          (c),
    .k          (lvl),
    .sum_exact  (core_exact),
    .sum_approx (core_approx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_exact_q  <= core_exact;
        s1_approx_q <= core_approx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_q      <= '0;
      y_q       <= '0;
      y_exact_q <= '0;
      err_q     <= '0;
    end else if (en) begin
      s2_q.valid <= s1_valid_q;
      if (s1_valid_q) begin
        y_q       <= s1_approx_q;
        y_exact_q <= s1_exact_q;
        err_q     <= s1_diff;
        s2_q.viol <= 32'(s1_diff) > ET;
      end
    end
  end

  // A clear coinciding with a handshake wins; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      txn_cnt_q  <= '0;
      viol_cnt_q <= '0;
      max_err_q  <= '0;
    end else if (hs) begin
      if (txn_cnt_q != {CNT_W{1'b1}}) txn_cnt_q <= txn_cnt_q + CNT_W'(1);
      if (s2_q.viol && (viol_cnt_q != {CNT_W{1'b1}})) viol_cnt_q <= viol_cnt_q + CNT_W'(1);
      if (err_q > max_err_q) max_err_q <= err_q;
    end
  end

  assign out_valid = s2_q.valid;
  assign viol      = s2_q.viol;
  assign y         = y_q;
  assign y_exact   = y_exact_q;
  assign err       = err_q;
  assign txn_cnt   = txn_cnt_q;
  assign viol_cnt  = viol_cnt_q;
  assign max_err   = max_err_q;

endmodule

// File: tb/tb_approx_madd_pipe.sv
// Randomised and directed bench for approx_madd_pipe against a slot-level reference model.
module tb_approx_madd_pipe;

  localparam int W     = 4;
  localparam int ET    = 7;
  localparam int OUT_W = 2 * W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [W-1:0]     a = '0, b = '0, c = '0;
  logic [3:0]       lvl = '0;
  logic             out_ready = 1'b0;
  logic             stat_clr = 1'b0;

  logic             in_ready, out_valid, viol;
  logic [OUT_W-1:0] y, y_exact, err, max_err;
  logic [15:0]      txn_cnt, viol_cnt;

  logic             in_ready_s, out_valid_s, viol_s;
  logic [OUT_W-1:0] y_s, y_exact_s, err_s, max_err_s;
  logic [1:0]       txn_cnt_s, viol_cnt_s;

  always #5 clk = ~clk;

  approx_madd_pipe #(.W(W), .ET(ET), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .lvl(lvl), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_exact(y_exact), .err(err), .viol(viol), .stat_clr(stat_clr),
    .txn_cnt(txn_cnt), .viol_cnt(viol_cnt), .max_err(max_err)
  );

  approx_madd_pipe #(.W(W), .ET(ET), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .c(c), .lvl(lvl), .out_valid(out_valid_s), .out_ready(out_ready),
    .y(y_s), .y_exact(y_exact_s), .err(err_s), .viol(viol_s), .stat_clr(stat_clr),
    .txn_cnt(txn_cnt_s), .viol_cnt(viol_cnt_s), .max_err(max_err_s)
  );

  typedef struct {
    bit v;
    int y;
    int ye;
    int err;
    bit viol;
  } slot_t;

  slot_t p0, p1, empty_slot;
  int    m_txn, m_viol, m_max;
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int min_i(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Row-wise view: for row i, only b bits with j >= kk-i survive.
  function automatic slot_t ref_slot(input int ia, input int ib, input int ic, input int k);
    slot_t s;
    int kk, sh;
    kk = (k > 2 * W - 2) ? 2 * W - 2 : k;
    s.v = 1'b1;
    s.ye = ia * ib + ic;
    s.y = ic;
    for (int i = 0; i < W; i++) begin
      if (((ia >> i) & 1) == 1) begin
        sh = (kk > i) ? kk - i : 0;
        s.y += ((ib >> sh) << sh) << i;
      end
    end
    s.err = s.ye - s.y;
    s.viol = s.err > ET;
    return s;
  endfunction

  task automatic step(input bit iv, input int ia, input int ib, input int ic, input int il,
                      input bit ordy, input bit clr);
    bit en_m;
    @(negedge clk);
    in_valid = iv;
    a = ia[W-1:0];
    b = ib[W-1:0];
    c = ic[W-1:0];
    lvl = il[3:0];
    out_ready = ordy;
    stat_clr = clr;
    #1;
    en_m = !p1.v || ordy;
    check_eq("out_valid", 32'(out_valid), 32'(p1.v));
    check_eq("in_ready", 32'(in_ready), 32'(en_m));
    if (p1.v) begin
      check_eq("y", 32'(y), p1.y);
      check_eq("y_exact", 32'(y_exact), p1.ye);
      check_eq("err", 32'(err), p1.err);
      check_eq("viol", 32'(viol), 32'(p1.viol));
      check_eq("y_sat_inst", 32'(y_s), p1.y);
    end
    check_eq("txn_cnt", 32'(txn_cnt), min_i(m_txn, 65535));
    check_eq("viol_cnt", 32'(viol_cnt), min_i(m_viol, 65535));
    check_eq("max_err", 32'(max_err), m_max);
    check_eq("txn_cnt_2b", 32'(txn_cnt_s), min_i(m_txn, 3));
    check_eq("viol_cnt_2b", 32'(viol_cnt_s), min_i(m_viol, 3));
    if (clr) begin
      m_txn = 0;
      m_viol = 0;
      m_max = 0;
    end else if (p1.v && ordy) begin
      m_txn++;
      if (p1.viol) m_viol++;
      if (p1.err > m_max) m_max = p1.err;
    end
    if (en_m) begin
      p1 = p0;
      p0 = iv ? ref_slot(ia, ib, ic, il) : empty_slot;
    end
  endtask

  task automatic do_reset(input bit iv, input bit ordy);
    @(negedge clk);
    rst = 1'b1;
    in_valid = iv;
    out_ready = ordy;
    stat_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_in_ready", 32'(in_ready), 1);
    check_eq("rst_y", 32'(y), 0);
    check_eq("rst_y_exact", 32'(y_exact), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_viol", 32'(viol), 0);
    check_eq("rst_txn_cnt", 32'(txn_cnt), 0);
    check_eq("rst_viol_cnt", 32'(viol_cnt), 0);
    check_eq("rst_max_err", 32'(max_err), 0);
    p0 = empty_slot;
    p1 = empty_slot;
    m_txn = 0;
    m_viol = 0;
    m_max = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sent;
    empty_slot = '{v: 1'b0, y: 0, ye: 0, err: 0, viol: 1'b0};
    do_reset(1'b0, 1'b1);

    // Exact mode, latency two cycles
    step(1, 15, 15, 15, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check_eq("lat_t1_valid", 32'(out_valid), 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check_eq("lat_t2_valid", 32'(out_valid), 1);
    check_eq("exact_y", 32'(y), 240);
    check_eq("exact_err", 32'(err), 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check_eq("exact_txn", 32'(txn_cnt), 1);

    // K=4 approximation
    step(1, 15, 15, 15, 4, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check_eq("k4_y", 32'(y), 191);
    check_eq("k4_y_exact", 32'(y_exact), 240);
    check_eq("k4_err", 32'(err), 49);
    check_eq("k4_viol", 32'(viol), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    check_eq("k4_viol_cnt", 32'(viol_cnt), 1);
    check_eq("k4_max_err", 32'(max_err), 49);

    // Backpressure: stall out_ready for three cycles while streaming five inputs
    sent = 0;
    for (int cyc = 0; cyc < 20 && sent < 5; cyc++) begin
      step(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), !(cyc >= 2 && cyc <= 4), 0);
      if (in_ready) sent++;
    end
    check_eq("bp_sent", 32'(sent), 5);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
    check_eq("bp_txn", 32'(txn_cnt), 7);

    // Clear on the same cycle as a handshake
    step(1, 15, 15, 15, 4, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    check_eq("clr_hs_err", 32'(err), 49);
    step(0, 0, 0, 0, 0, 1, 0);
    check_eq("clr_txn", 32'(txn_cnt), 0);
    check_eq("clr_viol", 32'(viol_cnt), 0);
    check_eq("clr_max", 32'(max_err), 0);

    // Saturation of the 2-bit instance
    for (int i = 0; i < 6; i++) step(1, 15, 15, 15, 4, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
    check_eq("sat_txn_2b", 32'(txn_cnt_s), 3);
    check_eq("sat_viol_2b", 32'(viol_cnt_s), 3);
    check_eq("sat_txn_16b", 32'(txn_cnt), 6);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 9) < 7,
           $urandom_range(0, 29) == 0);
    end

    // Mid-stream reset with both stages full
    step(1, 9, 13, 5, 3, 1, 0);
    step(1, 7, 11, 2, 5, 1, 0);
    step(1, 3, 3, 3, 1, 0, 0);
    check_eq("full_out_valid", 32'(out_valid), 1);
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15), 1, 0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
